sdram_arbiter: RTL and testbench

Three-port request/acknowledge arbiter sitting between the SoC's SDRAM clients (video line fetch, graphics rasterizer, CPU) and the single SDRAM controller command port inside `soc_top`. It lives entirely in the `clk_sdram` domain. Video has fixed top priority, bounded by a run limit so the lower ports cannot starve. CPU and rasterizer share the remaining slots round-robin. One transaction is in flight at a time, and every output is registered.

---
 rtl/sdram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM command arbiter: fixed-priority video with a bounded run,
// round-robin between rasterizer and CPU, one registered transaction in flight.
module sdram_arbiter #(
   parameter int ADDR_W        = 24,
   parameter int DATA_W        = 32,
   parameter int VIDEO_MAX_RUN = 4
) (
   input  logic                      clk_sdram,
   input  logic                      reset_i,
   input  logic [2:0]                req_i,
   input  logic [2:0]                we_i,
   input  logic [3*ADDR_W-1:0]       addr_i,
   input  logic [3*DATA_W-1:0]       wdata_i,
   input  logic [3*(DATA_W/8)-1:0]   wmask_i,
   output logic [2:0]                ack_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      cmd_valid_o,
   input  logic                      cmd_ready_i,
   output logic                      cmd_we_o,
   output logic [ADDR_W-1:0]         cmd_addr_o,
   output logic [DATA_W-1:0]         cmd_wdata_o,
   output logic [DATA_W/8-1:0]       cmd_wmask_o,
   input  logic                      rsp_valid_i,
   input  logic [DATA_W-1:0]         rsp_data_i
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          rr_last_q, rr_last_d;
   logic [2:0]          run_cnt_q, run_cnt_d;
   logic [1:0]          win;
   logic                others_pending;
   logic                video_wins;

   logic [2:0]          ack_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                cmd_valid_d;
   logic                cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_d;
   logic [MASK_W-1:0]   cmd_wmask_d;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   // Video yields only once its run limit is hit and someone else is waiting.
   always_comb begin
      others_pending = |req_i[2:1];
      video_wins     = req_i[0] && (!others_pending || (int'(run_cnt_q) < VIDEO_MAX_RUN));
      if (video_wins)
         win = 2'd0;
      else if (rr_last_q == 2'd2)
         win = req_i[1] ? 2'd1 : 2'd2;
      else
         win = req_i[2] ? 2'd2 : 2'd1;
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_last_d   = rr_last_q;
      run_cnt_d   = run_cnt_q;
      ack_d       = 3'b000;
      rdata_d     = rdata_o;
      cmd_valid_d = cmd_valid_o;
      cmd_we_d    = cmd_we_o;
      cmd_addr_d  = cmd_addr_o;
      cmd_wdata_d = cmd_wdata_o;
      cmd_wmask_d = cmd_wmask_o;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               state_d     = ISSUE;
               gnt_d       = win;
               cmd_valid_d = 1'b1;
               cmd_we_d    = we_i[win];
               cmd_addr_d  = addr_i[int'(win)*ADDR_W +: ADDR_W];
               cmd_wdata_d = wdata_i[int'(win)*DATA_W +: DATA_W];
               cmd_wmask_d = wmask_i[int'(win)*MASK_W +: MASK_W];
               if (win == 2'd0) begin
                  run_cnt_d = others_pending ? sat_inc(run_cnt_q) : 3'd0;
               end else begin
                  run_cnt_d = 3'd0;
                  rr_last_d = win;
               end
            end
         end
         ISSUE: begin
            if (cmd_ready_i) begin
               cmd_valid_d = 1'b0;
               if (cmd_we_o) begin
                  ack_d[gnt_q] = 1'b1;
                  state_d      = IDLE;
               end else begin
                  state_d = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (rsp_valid_i) begin
               rdata_d      = rsp_data_i;
               ack_d[gnt_q] = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset abandons any outstanding read; a late response lands in IDLE and is dropped.
   always_ff @(posedge clk_sdram) begin
      if (reset_i) begin
         state_q     <= IDLE;
         gnt_q       <= 2'd0;
         rr_last_q   <= 2'd2;
         run_cnt_q   <= 3'd0;
         ack_o       <= 3'b000;
         rdata_o     <= '0;
         cmd_valid_o <= 1'b0;
         cmd_we_o    <= 1'b0;
         cmd_addr_o  <= '0;
         cmd_wdata_o <= '0;
         cmd_wmask_o <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rr_last_q   <= rr_last_d;
         run_cnt_q   <= run_cnt_d;
         ack_o       <= ack_d;
         rdata_o     <= rdata_d;
         cmd_valid_o <= cmd_valid_d;
         cmd_we_o    <= cmd_we_d;
         cmd_addr_o  <= cmd_addr_d;
         cmd_wdata_o <= cmd_wdata_d;
         cmd_wmask_o <= cmd_wmask_d;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scenario bench for sdram_arbiter: expected commands/acks are queued when a
// request is driven and compared when the arbiter presents them.
module tb_sdram_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int MASK_W = DATA_W / 8;

   logic                    clk_sdram = 1'b0;
   logic                    reset_i;
   logic [2:0]              req_i;
   logic [2:0]              we_i;
   logic [3*ADDR_W-1:0]     addr_i;
   logic [3*DATA_W-1:0]     wdata_i;
   logic [3*MASK_W-1:0]     wmask_i;
   logic [2:0]              ack_o;
   logic [DATA_W-1:0]       rdata_o;
   logic                    cmd_valid_o;
   logic                    cmd_ready_i;
   logic                    cmd_we_o;
   logic [ADDR_W-1:0]       cmd_addr_o;
   logic [DATA_W-1:0]       cmd_wdata_o;
   logic [MASK_W-1:0]       cmd_wmask_o;
   logic                    rsp_valid_i;
   logic [DATA_W-1:0]       rsp_data_i;

   always #5 clk_sdram = ~clk_sdram;

   sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .VIDEO_MAX_RUN(4)) dut (
      .clk_sdram   (clk_sdram),
      .reset_i     (reset_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .wmask_i     (wmask_i),
      .ack_o       (ack_o),
      .rdata_o     (rdata_o),
      .cmd_valid_o (cmd_valid_o),
      .cmd_ready_i (cmd_ready_i),
      .cmd_we_o    (cmd_we_o),
      .cmd_addr_o  (cmd_addr_o),
      .cmd_wdata_o (cmd_wdata_o),
      .cmd_wmask_o (cmd_wmask_o),
      .rsp_valid_i (rsp_valid_i),
      .rsp_data_i  (rsp_data_i)
   );

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } cmd_t;

   cmd_t       exp_q[$];
   logic [2:0] ack_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic cmd_t obs_cmd();
      return {cmd_we_o, cmd_addr_o, cmd_wdata_o, cmd_wmask_o};
   endfunction

   task automatic set_port(input int p, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
      we_i[p]                     = we;
      addr_i[p*ADDR_W +: ADDR_W]  = a;
      wdata_i[p*DATA_W +: DATA_W] = d;
      wmask_i[p*MASK_W +: MASK_W] = m;
   endtask

   task automatic clear_inputs();
      req_i       = 3'b000;
      we_i        = 3'b000;
      addr_i      = '0;
      wdata_i     = '0;
      wmask_i     = '0;
      cmd_ready_i = 1'b1;
      rsp_valid_i = 1'b0;
      rsp_data_i  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_sdram);
      reset_i = 1'b1;
      clear_inputs();
      @(negedge clk_sdram);
      reset_i = 1'b0;
      exp_q.delete();
      ack_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk_sdram);
      reset_i = 1'b1;
      req_i   = 3'b111;
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'hFFFF_FFFF;
      @(negedge clk_sdram);
      n_checks++;
      if (cmd_valid_o !== 1'b0 || ack_o !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: valid=%b ack=%b, required 0/000", cmd_valid_o, ack_o);
      end
      n_checks++;
      if (obs_cmd() !== '0) begin
         n_fail++;
         $display("FAIL reset_cmd: cmd=%h, required 0", obs_cmd());
      end
      n_checks++;
      if (rdata_o !== '0) begin
         n_fail++;
         $display("FAIL reset_rdata: rdata=%h, required 0", rdata_o);
      end
      reset_i = 1'b0;
      clear_inputs();
   endtask

   task automatic test_cpu_write();
      cmd_t e;
      exp_q.push_back(cmd_t'{1'b1, 24'h000100, 32'hDEADBEEF, 4'hF});
      set_port(2, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF);
      req_i = 3'b100;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      n_checks++;
      if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
         n_fail++;
         $display("FAIL cpu_wr_cmd: valid=%b cmd=%h, required 1/%h", cmd_valid_o, obs_cmd(), e);
      end
      @(negedge clk_sdram);
      n_checks++;
      if (ack_o !== 3'b100) begin
         n_fail++;
         $display("FAIL cpu_wr_ack: ack=%b, required 100", ack_o);
      end
      req_i = 3'b000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sdram);
         n_checks++;
         if (cmd_valid_o !== 1'b0 || ack_o !== 3'b000) begin
            n_fail++;
            $display("FAIL cpu_wr_quiet: valid=%b ack=%b, required 0/000", cmd_valid_o, ack_o);
         end
      end
   endtask

   task automatic test_rast_read();
      cmd_t e;
      exp_q.push_back(cmd_t'{1'b0, 24'h001000, 32'h0, 4'h0});
      set_port(1, 1'b0, 24'h001000, 32'h0, 4'h0);
      req_i = 3'b010;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      n_checks++;
      if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
         n_fail++;
         $display("FAIL rast_rd_cmd: valid=%b cmd=%h, required 1/%h", cmd_valid_o, obs_cmd(), e);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sdram);
         n_checks++;
         if (ack_o !== 3'b000 || cmd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rast_rd_wait: ack=%b valid=%b, required 000/0", ack_o, cmd_valid_o);
         end
      end
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h12345678;
      @(negedge clk_sdram);
      rsp_valid_i = 1'b0;
      n_checks++;
      if (ack_o !== 3'b010 || rdata_o !== 32'h12345678) begin
         n_fail++;
         $display("FAIL rast_rd_ack: ack=%b rdata=%h, required 010/12345678", ack_o, rdata_o);
      end
      req_i = 3'b000;
      @(negedge clk_sdram);
      n_checks++;
      if (ack_o !== 3'b000 || cmd_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rast_rd_after: ack=%b valid=%b, required 000/0", ack_o, cmd_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      cmd_t e;
      for (int k = 0; k < 3; k++)
         exp_q.push_back(cmd_t'{1'b1, 24'h000200 + 24'(k), 32'hB0B0_0000 + 32'(k), 4'h3});
      set_port(2, 1'b1, 24'h000200, 32'hB0B0_0000, 4'h3);
      req_i = 3'b100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_sdram);
         e = exp_q.pop_front();
         n_checks++;
         if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
            n_fail++;
            $display("FAIL b2b_cmd%0d: valid=%b cmd=%h, required 1/%h", k, cmd_valid_o, obs_cmd(), e);
         end
         @(negedge clk_sdram);
         n_checks++;
         if (ack_o !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_ack%0d: ack=%b, required 100", k, ack_o);
         end
         if (k == 2) req_i = 3'b000;
         else set_port(2, 1'b1, 24'h000200 + 24'(k + 1), 32'hB0B0_0000 + 32'(k + 1), 4'h3);
      end
   endtask

   task automatic test_stall();
      cmd_t e;
      exp_q.push_back(cmd_t'{1'b1, 24'h2468AC, 32'hA5A55A5A, 4'h6});
      set_port(2, 1'b1, 24'h2468AC, 32'hA5A55A5A, 4'h6);
      cmd_ready_i = 1'b0;
      req_i = 3'b100;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (cmd_valid_o !== 1'b1 || obs_cmd() !== e || ack_o !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_hold%0d: valid=%b cmd=%h ack=%b, required 1/%h/000",
                     i, cmd_valid_o, obs_cmd(), ack_o, e);
         end
         @(negedge clk_sdram);
      end
      cmd_ready_i = 1'b1;
      @(negedge clk_sdram);
      n_checks++;
      if (ack_o !== 3'b100 || cmd_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_accept: ack=%b valid=%b, required 100/0", ack_o, cmd_valid_o);
      end
      req_i = 3'b000;
   endtask

   task automatic test_priority();
      logic [2:0] seq [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                               3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
      logic [2:0] e;
      int budget;
      do_reset();
      foreach (seq[i]) ack_q.push_back(seq[i]);
      for (int p = 0; p < 3; p++) set_port(p, 1'b1, 24'h000010 + 24'(p), 32'(p), 4'hF);
      req_i  = 3'b111;
      budget = 60;
      while (ack_q.size() > 0 && budget > 0) begin
         @(negedge clk_sdram);
         budget--;
         if (ack_o !== 3'b000) begin
            e = ack_q.pop_front();
            n_checks++;
            if (ack_o !== e) begin
               n_fail++;
               $display("FAIL prio_grant%0d: ack=%b, required %b", 10 - ack_q.size(), ack_o, e);
            end
            if (ack_q.size() == 0) req_i = 3'b000;
         end
      end
      n_checks++;
      if (ack_q.size() != 0) begin
         n_fail++;
         $display("FAIL prio_timeout: %0d grants missing, required 0", ack_q.size());
      end
      req_i = 3'b000;
   endtask

   task automatic test_video_alone();
      int budget;
      int seen;
      do_reset();
      for (int p = 0; p < 3; p++) set_port(p, 1'b1, 24'h000020 + 24'(p), 32'(p), 4'hF);
      req_i  = 3'b111;
      budget = 40;
      seen   = 0;
      while (seen < 5 && budget > 0) begin
         @(negedge clk_sdram);
         budget--;
         if (ack_o !== 3'b000) begin
            n_checks++;
            if (ack_o !== 3'b001) begin
               n_fail++;
               $display("FAIL video_alone%0d: ack=%b, required 001", seen, ack_o);
            end
            seen++;
            if (seen == 4) req_i = 3'b001;
            if (seen == 5) req_i = 3'b000;
         end
      end
      n_checks++;
      if (seen != 5) begin
         n_fail++;
         $display("FAIL video_alone_timeout: grants=%0d, required 5", seen);
      end
      req_i = 3'b000;
   endtask

   task automatic test_reset_in_wait_rd();
      cmd_t e;
      exp_q.push_back(cmd_t'{1'b0, 24'h003000, 32'h0, 4'h0});
      set_port(2, 1'b0, 24'h003000, 32'h0, 4'h0);
      req_i = 3'b100;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      n_checks++;
      if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
         n_fail++;
         $display("FAIL rst_rd_cmd: valid=%b cmd=%h, required 1/%h", cmd_valid_o, obs_cmd(), e);
      end
      @(negedge clk_sdram);
      reset_i = 1'b1;
      req_i   = 3'b000;
      @(negedge clk_sdram);
      reset_i = 1'b0;
      n_checks++;
      if (cmd_valid_o !== 1'b0 || ack_o !== 3'b000 || obs_cmd() !== '0 || rdata_o !== '0) begin
         n_fail++;
         $display("FAIL rst_rd_outputs: valid=%b ack=%b cmd=%h rdata=%h, required all 0",
                  cmd_valid_o, ack_o, obs_cmd(), rdata_o);
      end
      @(negedge clk_sdram);
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h99999999;
      @(negedge clk_sdram);
      rsp_valid_i = 1'b0;
      n_checks++;
      if (ack_o !== 3'b000 || rdata_o !== '0 || cmd_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_rd_late_rsp: ack=%b rdata=%h valid=%b, required 000/0/0",
                  ack_o, rdata_o, cmd_valid_o);
      end
      exp_q.push_back(cmd_t'{1'b1, 24'h003004, 32'h0BADF00D, 4'h9});
      set_port(2, 1'b1, 24'h003004, 32'h0BADF00D, 4'h9);
      req_i = 3'b100;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      n_checks++;
      if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
         n_fail++;
         $display("FAIL rst_post_cmd: valid=%b cmd=%h, required 1/%h", cmd_valid_o, obs_cmd(), e);
      end
      @(negedge clk_sdram);
      n_checks++;
      if (ack_o !== 3'b100) begin
         n_fail++;
         $display("FAIL rst_post_ack: ack=%b, required 100", ack_o);
      end
      req_i = 3'b000;
   endtask

   task automatic test_rsp_idle();
      cmd_t e;
      exp_q.push_back(cmd_t'{1'b0, 24'h004000, 32'h0, 4'h0});
      set_port(2, 1'b0, 24'h004000, 32'h0, 4'h0);
      req_i = 3'b100;
      @(negedge clk_sdram);
      e = exp_q.pop_front();
      n_checks++;
      if (cmd_valid_o !== 1'b1 || obs_cmd() !== e) begin
         n_fail++;
         $display("FAIL idle_rd_cmd: valid=%b cmd=%h, required 1/%h", cmd_valid_o, obs_cmd(), e);
      end
      @(negedge clk_sdram);
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'hCAFEF00D;
      @(negedge clk_sdram);
      rsp_valid_i = 1'b0;
      req_i       = 3'b000;
      n_checks++;
      if (ack_o !== 3'b100 || rdata_o !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL idle_rd_ack: ack=%b rdata=%h, required 100/cafef00d", ack_o, rdata_o);
      end
      @(negedge clk_sdram);
      rsp_valid_i = 1'b1;
      rsp_data_i  = 32'h55555555;
      @(negedge clk_sdram);
      rsp_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ack_o !== 3'b000 || rdata_o !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL idle_rsp_ignored%0d: ack=%b rdata=%h, required 000/cafef00d",
                     i, ack_o, rdata_o);
         end
         @(negedge clk_sdram);
      end
   endtask

   initial begin
      reset_i = 1'b1;
      clear_inputs();
      do_reset();
      test_reset();
      test_cpu_write();
      test_rast_read();
      test_back_to_back();
      test_stall();
      test_priority();
      test_video_alone();
      test_reset_in_wait_rd();
      test_rsp_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
